tm1638_display_writer: RTL and testbench
========================================

Name: tm1638_display_writer

Overview:
Downstream stage of the BCD-to-7-segment decoders. Takes eight segment bytes (one per digit, DP G F E D C B A, 1 = segment lit) and eight discrete LED bits, and serially writes them to a TM1638 board over STB/CLK/DIO. This block is write-only: no key scan and no DIO readback. Each update is a single start pulse; refresh policy belongs to the parent.

Parameters:
CLK_DIV, 25, half bit period in clk cycles (D); minimum 1; 25 at 50 MHz gives a 1 MHz serial clock.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; accepted only when busy=0
seg_data  input  64  digit k segment byte at [8k+7:8k], k=0..7 (digit 0 leftmost)
leds  input  8  leds[k] drives the discrete LED above digit k
brightness  input  3  TM1638 pulse-width setting 0..7
display_on  input  1  1 = display enabled
busy  output  1  high from the accept cycle +1 until done
done  output  1  one-cycle pulse at end of update
tm_stb  output  1  TM1638 strobe, active low
tm_clk  output  1  TM1638 serial clock
tm_dio  output  1  TM1638 data, driven LSB first

Behaviour:
- Reset (async): tm_stb=1, tm_clk=1, tm_dio=1, busy=0, done=0, FSM=IDLE. Reset mid-transfer aborts immediately to these values.
- All outputs registered. In IDLE, and whenever tm_stb=1, tm_clk=1 and tm_dio=1.
- Accept: start=1 in IDLE at cycle 0. The block latches seg_data, leds, brightness and display_on that cycle. Input changes while busy are ignored. start while busy is ignored and not queued.
- FSM: IDLE -> T1 -> GAP1 -> T2 -> GAP2 -> T3 -> TAIL -> IDLE.
  - T1 sends byte 0x40 (data write, auto-increment).
  - T2 sends 0xC0 (address 0), then 16 data bytes:
    - address 2k = seg_data[8k+7:8k]
    - address 2k+1 = {7'b0, leds[k]}
  - T3 sends 0x80 | display_on<<3 | brightness.
- Transaction framing (T1/T2/T3):
  - tm_stb low for the whole transaction.
  - First D cycles: setup, tm_clk=1.
  - Each bit then takes 2D cycles. tm_clk=0 for D cycles, with tm_dio updated on the first cycle of the low phase. tm_clk=1 for the next D cycles, and the TM1638 samples on the rise.
  - Bytes are back-to-back, LSB first.
  - After the last bit: D hold cycles, tm_clk=1, then tm_stb rises.
  - Lengths: T1 = 18D cycles, T2 = 274D cycles, T3 = 18D cycles.
- GAP1, GAP2 and TAIL: tm_stb=1 for 2D cycles each.
- Timeline from cycle 0:
  - tm_stb falls at cycle 1, and busy=1 from cycle 1.
  - T1 low on cycles 1..18D.
  - T2 low from 20D+1 to 294D.
  - T3 low from 296D+1 to 314D.
  - tm_stb final rise at cycle 314D+1.
  - done=1 and busy=0 at cycle 316D+1, with FSM back in IDLE.
- A start in the done cycle is accepted; that cycle is its cycle 0.
- Counters: a divider of width clog2(CLK_DIV)+1; a 3-bit bit index; a 5-bit byte index (0..16) for T2. Wrap of the bit index from 7 to 0 advances the byte index. No other wrap conditions.
- CLK_DIV=1 is legal: tm_clk toggles every cycle.

Test Plan:
1. Reset: assert rst mid-T2 with CLK_DIV=2 -> same cycle tm_stb=1, tm_clk=1, tm_dio=1, busy=0. After release, no activity until start.
2. Single update with CLK_DIV=2, seg_data=64'h3F06_5B4F_666D_7D07 (bytes in reverse digit order), leds=8'hA5, brightness=3'd7, display_on=1. Decode DIO on tm_clk rises, framed by tm_stb:
   - T1 = 0x40.
   - T2 = C0, 07,01, 7D,00, 6D,01, 66,00, 4F,00, 5B,01, 06,00, 3F,01. Digit 0 = 0x07.
   - T3 = 0x8F.
   - done at cycle 633, busy high on cycles 1..632.
3. Timing check, CLK_DIV=3: each tm_clk low and high phase = 3 cycles. tm_dio stable throughout each high phase. tm_stb high gaps = 6 cycles. done at 949.
4. start pulsed at cycle 100 while busy, with changed seg_data -> ignored. Output stream matches the originally latched data, and exactly one done.
5. start asserted in the done cycle with display_on=0, brightness=0 -> new tm_stb fall on the next cycle; T3 of the second update = 0x80.
6. CLK_DIV=1 -> tm_clk toggles every cycle during bits; done at cycle 317; decoded bytes correct.

Source files
------------

// File: rtl/tm1638_display_writer_if.sv
// Parallel side of the TM1638 display writer: update request/status plus
// the three-wire serial link (STB/CLK/DIO) to the TM1638 board.
interface tm1638_display_writer_if;
   logic        start;
   logic [63:0] seg_data;
   logic [7:0]  leds;
   logic [2:0]  brightness;
   logic        display_on;
   logic        busy;
   logic        done;
   logic        tm_stb;
   logic        tm_clk;
   logic        tm_dio;

   modport master (
      output start, seg_data, leds, brightness, display_on,
      input  busy, done, tm_stb, tm_clk, tm_dio
   );

   modport slave (
      input  start, seg_data, leds, brightness, display_on,
      output busy, done, tm_stb, tm_clk, tm_dio
   );
endinterface

// File: rtl/tm1638_display_writer.sv
// TM1638 display writer: on one start pulse, latches eight segment bytes,
// eight LED bits and the brightness setting, then sends the three TM1638
// transactions (data-write command, address-0 + 16 data bytes, display
// control) over STB/CLK/DIO, LSB first. Write-only, no key scan.
module tm1638_display_writer #(
   parameter int CLK_DIV = 25
) (
   input  logic                   clk,
   input  logic                   rst,
   tm1638_display_writer_if.slave bus
);
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_GAP1 = 3'd2;
   localparam logic [2:0] S_T2   = 3'd3;
   localparam logic [2:0] S_GAP2 = 3'd4;
   localparam logic [2:0] S_T3   = 3'd5;
   localparam logic [2:0] S_TAIL = 3'd6;

   // Slots of D cycles inside a transaction; gaps use SETUP/LOW as halves.
   localparam logic [1:0] P_SETUP = 2'd0;
   localparam logic [1:0] P_LOW   = 2'd1;
   localparam logic [1:0] P_HIGH  = 2'd2;
   localparam logic [1:0] P_HOLD  = 2'd3;

   logic [2:0]    state_q;
   logic [1:0]    phase_q;
   logic [DW-1:0] div_q;
   logic [2:0]    bit_q;
   logic [4:0]    byte_q;
   logic [63:0]   seg_q;
   logic [7:0]    leds_q;
   logic [2:0]    bri_q;
   logic          on_q;
   logic          busy_q;
   logic          done_q;
   logic          stb_q;
   logic          sclk_q;
   logic          dio_q;

   logic          slot_end;
   logic          is_xfer;
   logic          last_bit;
   logic [4:0]    last_byte;
   logic [2:0]    nxt_bit;
   logic [4:0]    nxt_byte;
   logic [3:0]    addr;
   logic [7:0]    tx_byte;
   logic          nxt_dio;
   logic [2:0]    after_state;

   // Slot timing, position of the next bit to shift out, successor state
   always_comb begin
      slot_end  = (div_q == DIV_LAST);
      is_xfer   = (state_q == S_T1) || (state_q == S_T2) || (state_q == S_T3);
      last_byte = (state_q == S_T2) ? 5'd16 : 5'd0;
      last_bit  = (bit_q == 3'd7) && (byte_q == last_byte);
      if (phase_q == P_HIGH) begin
         nxt_bit  = bit_q + 3'd1;
         nxt_byte = byte_q + {4'd0, bit_q == 3'd7};
      end else begin
         nxt_bit  = 3'd0;
         nxt_byte = 5'd0;
      end
      case (state_q)
         S_T1:    after_state = S_GAP1;
         S_GAP1:  after_state = S_T2;
         S_T2:    after_state = S_GAP2;
         S_GAP2:  after_state = S_T3;
         S_T3:    after_state = S_TAIL;
         default: after_state = S_IDLE;
      endcase
   end

   // Byte being sent for the next bit: command bytes, or address-ordered data
   always_comb begin
      addr    = nxt_byte[3:0] - 4'd1;
      tx_byte = 8'h00;
      case (state_q)
         S_T1: tx_byte = 8'h40;
         S_T3: tx_byte = {4'h8, on_q, bri_q};
         S_T2: begin
            if (nxt_byte == 5'd0)
               tx_byte = 8'hC0;
            else if (addr[0])
               tx_byte = {7'd0, leds_q[addr[3:1]]};
            else
               tx_byte = seg_q[{addr[3:1], 3'b000} +: 8];
         end
         default: tx_byte = 8'h00;
      endcase
      nxt_dio = tx_byte[nxt_bit];
   end

   // Sequencer: accept/latch, slot divider, serial line drive, done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= P_SETUP;
         div_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         seg_q   <= '0;
         leds_q  <= '0;
         bri_q   <= '0;
         on_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         stb_q   <= 1'b1;
         sclk_q  <= 1'b1;
         dio_q   <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (state_q == S_IDLE) begin
            if (bus.start) begin
               seg_q   <= bus.seg_data;
               leds_q  <= bus.leds;
               bri_q   <= bus.brightness;
               on_q    <= bus.display_on;
               state_q <= S_T1;
               phase_q <= P_SETUP;
               div_q   <= '0;
               busy_q  <= 1'b1;
               stb_q   <= 1'b0;
            end
         end else if (!slot_end) begin
            div_q <= div_q + DW'(1);
         end else begin
            div_q <= '0;
            if (is_xfer) begin
               case (phase_q)
                  P_SETUP: begin
                     phase_q <= P_LOW;
                     bit_q   <= 3'd0;
                     byte_q  <= 5'd0;
                     sclk_q  <= 1'b0;
                     dio_q   <= nxt_dio;
                  end
                  P_LOW: begin
                     phase_q <= P_HIGH;
                     sclk_q  <= 1'b1;
                  end
                  P_HIGH: begin
                     if (last_bit) begin
                        phase_q <= P_HOLD;
                     end else begin
                        phase_q <= P_LOW;
                        bit_q   <= nxt_bit;
                        byte_q  <= nxt_byte;
                        sclk_q  <= 1'b0;
                        dio_q   <= nxt_dio;
                     end
                  end
                  default: begin
                     state_q <= after_state;
                     phase_q <= P_SETUP;
                     stb_q   <= 1'b1;
                     dio_q   <= 1'b1;
                  end
               endcase
            end else if (phase_q == P_SETUP) begin
               phase_q <= P_LOW;
            end else begin
               phase_q <= P_SETUP;
               state_q <= after_state;
               if (state_q == S_TAIL) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  stb_q <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.tm_stb = stb_q;
   assign bus.tm_clk = sclk_q;
   assign bus.tm_dio = dio_q;
endmodule

// File: tb/tb_tm1638_display_writer.sv
// Scoreboard bench for tm1638_display_writer: three instances (CLK_DIV 2, 3, 1).
// Stimulus pushes expected bytes, frame lengths and event cycles; one monitor
// decodes the serial lines on the falling clock edge and compares.
module tb_tm1638_display_writer;
   typedef logic [7:0] upd_t [19];

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start_v [3];
   logic [63:0] seg_v   [3];
   logic [7:0]  leds_v  [3];
   logic [2:0]  bri_v   [3];
   logic        on_v    [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        stb_v   [3];
   logic        sclk_v  [3];
   logic        dio_v   [3];

   logic [7:0] q_byte [3][$];
   int         q_bits [3][$];
   int         q_fall [3][$];
   int         q_done [3][$];

   int   tests = 0;
   int   fails = 0;
   logic end_req = 1'b0;
   logic end_ack = 1'b0;

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 3 : 1;
   endfunction

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         localparam int D = (g == 0) ? 2 : (g == 1) ? 3 : 1;
         tm1638_display_writer_if bus ();
         assign bus.start      = start_v[g];
         assign bus.seg_data   = seg_v[g];
         assign bus.leds       = leds_v[g];
         assign bus.brightness = bri_v[g];
         assign bus.display_on = on_v[g];
         assign busy_v[g]      = bus.busy;
         assign done_v[g]      = bus.done;
         assign stb_v[g]       = bus.tm_stb;
         assign sclk_v[g]      = bus.tm_clk;
         assign dio_v[g]       = bus.tm_dio;
         tm1638_display_writer #(.CLK_DIV(D)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
         );
      end
   endgenerate

   function automatic upd_t model(input logic [63:0] seg, input logic [7:0] ld,
                                  input logic [2:0] br, input logic on);
      upd_t m;
      m[0] = 8'h40;
      m[1] = 8'hC0;
      for (int k = 0; k < 8; k++) begin
         m[2 + 2 * k] = seg[8 * k +: 8];
         m[3 + 2 * k] = {7'd0, ld[k]};
      end
      m[18] = {4'h8, on, br};
      return m;
   endfunction

   task automatic chk(input string name, input int i, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s dut%0d @cyc %0d: got %0h, expected %0h", name, i, cyc, act, exp);
      end
   endtask

   // Monitor state per instance
   logic       p_stb  [3];
   logic       p_clk  [3];
   logic       gap_ok [3];
   logic [7:0] sh     [3];
   logic       held   [3];
   int         nbits  [3];
   int         lo_run [3];
   int         hi_run [3];
   int         stb_run[3];
   int         busy_run[3];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int d;
         d = div_of(i);
         if (rst) begin
            chk("reset_stb", i, stb_v[i], 1);
            chk("reset_clk", i, sclk_v[i], 1);
            chk("reset_dio", i, dio_v[i], 1);
            chk("reset_busy", i, busy_v[i], 0);
            chk("reset_done", i, done_v[i], 0);
            q_byte[i].delete();
            q_bits[i].delete();
            q_fall[i].delete();
            q_done[i].delete();
            p_stb[i] = 1'b1;   p_clk[i] = 1'b1;  gap_ok[i] = 1'b0;
            nbits[i] = 0;      lo_run[i] = 0;    hi_run[i] = 0;
            stb_run[i] = 0;    busy_run[i] = 0;
         end else begin
            if (done_v[i]) begin
               if (q_done[i].size() == 0) chk("done_queue", i, q_done[i].size(), 1);
               else chk("done_cycle", i, cyc, q_done[i].pop_front());
               chk("busy_at_done", i, busy_v[i], 0);
               chk("busy_len", i, busy_run[i], 316 * d);
               chk("tail_len", i, stb_run[i], 2 * d);
            end
            if (p_stb[i] && !stb_v[i]) begin
               if (gap_ok[i]) chk("gap_len", i, stb_run[i], 2 * d);
               else if (q_fall[i].size() == 0) chk("fall_queue", i, q_fall[i].size(), 1);
               else chk("stb_fall_cycle", i, cyc, q_fall[i].pop_front());
               nbits[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
            end
            if (!stb_v[i]) begin
               if (sclk_v[i] && !p_clk[i]) begin
                  chk("clk_low_len", i, lo_run[i], d);
                  sh[i]   = {dio_v[i], sh[i][7:1]};
                  held[i] = dio_v[i];
                  nbits[i]++;
                  hi_run[i] = 0;
                  if (nbits[i] % 8 == 0) begin
                     if (q_byte[i].size() == 0) chk("byte_queue", i, q_byte[i].size(), 1);
                     else chk("byte", i, sh[i], q_byte[i].pop_front());
                  end
               end else if (!sclk_v[i] && p_clk[i]) begin
                  chk("clk_high_len", i, hi_run[i], d);
                  lo_run[i] = 0;
               end else if (sclk_v[i] && nbits[i] > 0 && hi_run[i] < d) begin
                  chk("dio_stable", i, dio_v[i], held[i]);
               end
               if (sclk_v[i]) hi_run[i]++;
               else lo_run[i]++;
            end
            if (!p_stb[i] && stb_v[i]) begin
               chk("hold_len", i, hi_run[i], 2 * d);
               if (q_bits[i].size() == 0) chk("frame_queue", i, q_bits[i].size(), 1);
               else chk("frame_bits", i, nbits[i], q_bits[i].pop_front());
               stb_run[i] = 0;
               gap_ok[i]  = 1'b1;
            end
            if (stb_v[i]) begin
               chk("idle_clk", i, sclk_v[i], 1);
               chk("idle_dio", i, dio_v[i], 1);
               stb_run[i]++;
               if (!busy_v[i]) gap_ok[i] = 1'b0;
            end
            if (busy_v[i]) busy_run[i]++;
            else busy_run[i] = 0;
            p_stb[i] = stb_v[i];
            p_clk[i] = sclk_v[i];
         end
      end
      if (end_req && !end_ack) begin
         for (int i = 0; i < 3; i++) begin
            chk("left_bytes", i, q_byte[i].size(), 0);
            chk("left_frames", i, q_bits[i].size(), 0);
            chk("left_falls", i, q_fall[i].size(), 0);
            chk("left_dones", i, q_done[i].size(), 0);
         end
         end_ack = 1'b1;
      end
   end

   task automatic issue(input int i, input logic [63:0] seg, input logic [7:0] ld,
                        input logic [2:0] br, input logic on, input upd_t exp, input bit now);
      int s;
      if (!now) @(negedge clk);
      seg_v[i]   = seg;
      leds_v[i]  = ld;
      bri_v[i]   = br;
      on_v[i]    = on;
      start_v[i] = 1'b1;
      s = cyc;
      foreach (exp[b]) q_byte[i].push_back(exp[b]);
      q_bits[i].push_back(8);
      q_bits[i].push_back(136);
      q_bits[i].push_back(8);
      q_fall[i].push_back(s + 1);
      q_done[i].push_back(s + 316 * div_of(i) + 1);
      @(negedge clk);
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget);
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done_v[i]) break;
      end
   endtask

   upd_t t2_hand;

   initial begin
      t2_hand = '{8'h40, 8'hC0, 8'h07, 8'h01, 8'h7D, 8'h00, 8'h6D, 8'h01, 8'h66, 8'h00,
                  8'h4F, 8'h00, 8'h5B, 8'h01, 8'h06, 8'h00, 8'h3F, 8'h01, 8'h8F};
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; seg_v[i] = '0; leds_v[i] = '0; bri_v[i] = '0; on_v[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Reset in the middle of T2, then quiet lines until the next start
      issue(0, 64'h0123_4567_89AB_CDEF, 8'h3C, 3'd2, 1'b1,
            model(64'h0123_4567_89AB_CDEF, 8'h3C, 3'd2, 1'b1), 1'b0);
      repeat (100) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) @(negedge clk);

      // Full update, D=2, hand-decoded stream
      issue(0, 64'h3F06_5B4F_666D_7D07, 8'hA5, 3'd7, 1'b1, t2_hand, 1'b0);
      wait_done(0, 700);

      // D=3 timing; start with new data at cycle 100 must be ignored
      issue(1, 64'h7F6F_7739_5E79_7100, 8'h81, 3'd4, 1'b1,
            model(64'h7F6F_7739_5E79_7100, 8'h81, 3'd4, 1'b1), 1'b0);
      repeat (99) @(negedge clk);
      start_v[1] = 1'b1;
      seg_v[1]   = 64'hFFFF_FFFF_FFFF_FFFF;
      leds_v[1]  = 8'h00;
      bri_v[1]   = 3'd1;
      on_v[1]    = 1'b0;
      @(negedge clk);
      start_v[1] = 1'b0;
      wait_done(1, 1000);

      // Back-to-back: second start in the done cycle, display off, brightness 0
      issue(0, 64'h0011_2233_4455_6677, 8'h0F, 3'd5, 1'b1,
            model(64'h0011_2233_4455_6677, 8'h0F, 3'd5, 1'b1), 1'b0);
      wait_done(0, 700);
      issue(0, 64'h8899_AABB_CCDD_EEFF, 8'hF0, 3'd0, 1'b0,
            model(64'h8899_AABB_CCDD_EEFF, 8'hF0, 3'd0, 1'b0), 1'b1);
      wait_done(0, 700);

      // D=1: clock toggles every cycle
      issue(2, 64'h6D7D_0766_4F5B_063F, 8'h5A, 3'd3, 1'b1,
            model(64'h6D7D_0766_4F5B_063F, 8'h5A, 3'd3, 1'b1), 1'b0);
      wait_done(2, 400);

      repeat (1000) @(negedge clk);
      end_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
